// File: rtl/uart_tx_core.sv
// UART transmit engine: programmable 5-8 data bits, optional parity, 1/2 stop bits, LSB first.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_core #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       pclk,
  input  logic       presetn,
`ifdef UART_TX_BREAK_EN
  input  logic       send_break,
`endif
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  input  logic [4:0] cfg,
  output logic       tx,
  output logic       tx_busy,
  output logic       set_tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(BAUD_DIV - 1);

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic             r_stop_idx, w_stop_idx_nxt;
  logic             r_start_q, r_tx, r_busy, r_done;
  logic             w_tx_nxt, w_busy_nxt, w_done_nxt, w_load;
  logic [7:0]       r_sh_data;
  logic [4:0]       r_sh_cfg;
  logic             w_req, w_break, w_bit_end, w_last_data, w_parity;
  logic [7:0]       w_data_mask;

`ifdef UART_TX_BREAK_EN
  assign w_break = send_break;
`else
  assign w_break = 1'b0;
`endif

  assign w_req       = start_tx & ~r_start_q;
  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  // Last data index is (bits - 1) = cfg[1:0] + 4.
  assign w_last_data = (r_bit_idx == {1'b1, r_sh_cfg[1:0]});
  assign w_parity    = (^(r_sh_data & w_data_mask)) ^ r_sh_cfg[4];

  always_comb begin
    case (r_sh_cfg[1:0])
      2'b00:   w_data_mask = 8'h1F;
      2'b01:   w_data_mask = 8'h3F;
      2'b10:   w_data_mask = 8'h7F;
      default: w_data_mask = 8'hFF;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt + DIV_W'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_req && !w_break) begin
          w_load         = 1'b1;
          w_state_nxt    = S_START;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_bit_idx_nxt  = '0;
          w_stop_idx_nxt = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (w_last_data) begin
            w_state_nxt    = r_sh_cfg[3] ? S_PARITY : S_STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_stop_idx_nxt = 1'b0;
          w_state_nxt    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (r_stop_idx == r_sh_cfg[2]) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is decided from the next state so tx changes on the same edge as the state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_tx_nxt = ~w_break;
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_sh_data[w_bit_idx_nxt];
      S_PARITY: w_tx_nxt = w_parity;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_start_q  <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_start_q  <= start_tx;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Shadow copies are pure data; they are only meaningful once a frame has been accepted.
  always_ff @(posedge pclk) begin
    if (w_load) begin
      r_sh_data <= tx_data;
      r_sh_cfg  <= cfg;
    end
  end

  assign tx          = r_tx;
  assign tx_busy     = r_busy;
  assign set_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with BAUD_DIV=4; expected line levels are hand-built frames.
module tb_uart_tx_core;

  logic       pclk;
  logic       presetn;
  logic [7:0] tx_data;
  logic       start_tx;
  logic [4:0] cfg;
  logic       tx;
  logic       tx_busy;
  logic       set_tx_done;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_core #(.BAUD_DIV(4), .DIV_W(16)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .tx_data    (tx_data),
    .start_tx   (start_tx),
    .cfg        (cfg),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .set_tx_done(set_tx_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called on a negedge. bits[0] is the start bit, then data LSB first, parity, stop(s).
  // glitch>0 drops start_tx at that cycle and re-raises it with new data/cfg one cycle later.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic [4:0] c,
                            input logic [15:0] bits, input int nbits, input int glitch);
    int cyc;
    cyc = 0;
    tx_data  = data;
    cfg      = c;
    start_tx = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge pclk);
        cyc++;
        check({tag, "_tx"}, tx, bits[b]);
        check({tag, "_busy"}, tx_busy, 1'b1);
        if (cyc == 1) check({tag, "_done_clr"}, set_tx_done, 1'b0);
        if (glitch > 0 && cyc == glitch) start_tx = 1'b0;
        if (glitch > 0 && cyc == glitch + 1) begin
          start_tx = 1'b1;
          tx_data  = 8'h00;
          cfg      = 5'b01100;
        end
      end
    end
    @(negedge pclk);
    check({tag, "_done"}, set_tx_done, 1'b1);
    check({tag, "_idle_busy"}, tx_busy, 1'b0);
    check({tag, "_idle_tx"}, tx, 1'b1);
    start_tx = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    presetn  = 1'b0;
    start_tx = 1'b0;
    tx_data  = 8'h00;
    cfg      = 5'b00000;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    #12;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", set_tx_done, 1'b0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // 8N1, A5
    send_frame("f8n1_a5", 8'hA5, 5'b00011, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);
    // 8E1 / 8O1 with 07 (three ones)
    send_frame("f8e1_07", 8'h07, 5'b01011, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 0);
    send_frame("f8o1_07", 8'h07, 5'b11011, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 0);
    // 5N2 with FF: 32-cycle frame
    send_frame("f5n2_ff", 8'hFF, 5'b00100, 16'({2'b11, 5'b11111, 1'b0}), 8, 0);
    // 5N1 with E0: upper ones must not be sent
    send_frame("f5n1_e0", 8'hE0, 5'b00000, 16'({1'b1, 5'b00000, 1'b0}), 7, 0);
    // 5E1 with E1: parity covers only the low five bits (one 1 -> parity 1)
    send_frame("f5e1_e1", 8'hE1, 5'b01000, 16'({1'b1, 1'b1, 5'b00001, 1'b0}), 8, 0);
    // 7O1 with 55: four ones -> odd parity 1
    send_frame("f7o1_55", 8'h55, 5'b11010, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, 0);
    // 6N2 with 2C
    send_frame("f6n2_2c", 8'h2C, 5'b00101, 16'({2'b11, 6'h2C, 1'b0}), 9, 0);

    // Mid-frame start edge plus data/cfg change: original frame only, nothing queued
    send_frame("midreq", 8'hA5, 5'b00011, 16'({1'b1, 8'hA5, 1'b0}), 10, 12);
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      check("midreq_noq_tx", tx, 1'b1);
      check("midreq_noq_busy", tx_busy, 1'b0);
    end

    // Asynchronous reset during DATA
    tx_data  = 8'hA5;
    cfg      = 5'b00011;
    start_tx = 1'b1;
    repeat (10) @(negedge pclk);
    check("arst_pre_busy", tx_busy, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_busy", tx_busy, 1'b0);
    check("arst_done", set_tx_done, 1'b0);
    start_tx = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("arst_idle_tx", tx, 1'b1);
    send_frame("after_rst", 8'h3C, 5'b01011, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 0);

    // Request in the completing cycle is ignored (5N1, 28 cycles)
    tx_data  = 8'h00;
    cfg      = 5'b00000;
    start_tx = 1'b1;
    @(negedge pclk);
    start_tx = 1'b0;
    repeat (27) @(negedge pclk);
    check("samecyc_busy", tx_busy, 1'b1);
    start_tx = 1'b1;
    @(negedge pclk);
    check("samecyc_done", set_tx_done, 1'b1);
    check("samecyc_idle", tx_busy, 1'b0);
    @(negedge pclk);
    check("samecyc_ign_busy", tx_busy, 1'b0);
    check("samecyc_ign_tx", tx, 1'b1);
    check("samecyc_ign_done", set_tx_done, 1'b1);

    // Back-to-back: request one cycle after completion, done high for one cycle
    start_tx = 1'b0;
    @(negedge pclk);
    start_tx = 1'b1;
    @(negedge pclk);
    start_tx = 1'b0;
    repeat (27) @(negedge pclk);
    @(negedge pclk);
    check("b2b_done", set_tx_done, 1'b1);
    start_tx = 1'b1;
    @(negedge pclk);
    check("b2b_done_clr", set_tx_done, 1'b0);
    check("b2b_busy", tx_busy, 1'b1);
    check("b2b_start", tx, 1'b0);
    repeat (27) @(negedge pclk);
    @(negedge pclk);
    check("b2b_done2", set_tx_done, 1'b1);
    start_tx = 1'b0;
    @(negedge pclk);

`ifdef UART_TX_BREAK_EN
    send_break = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge pclk);
      check("brk_tx", tx, 1'b0);
      check("brk_busy", tx_busy, 1'b0);
      if (i == 5) start_tx = 1'b1;
      if (i == 20) send_break = 1'b0;
    end
    @(negedge pclk);
    check("brk_rel_tx", tx, 1'b1);
    check("brk_rel_busy", tx_busy, 1'b0);
    start_tx = 1'b0;
    @(negedge pclk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
